gpio_debounce_scheduler: RTL and testbench

Time-multiplexed debounce engine for the GPIO switch/button inputs (8 switches + 5 buttons by default).
- One shared prescaler and one compare/increment unit are scheduled round-robin across all channels; per-channel state is a counter register only.
- Sits between the raw pad synchronisers and the GPIO register/interrupt logic, which consumes the clean levels and edge pulses.
- Per-channel enable and the debounce threshold come from the GPIO register file.

---
 rtl/gpio_debounce_scheduler.sv | 121 ++++++++++++
 tb/tb_gpio_debounce_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce_scheduler.sv
// gpio_debounce_scheduler: round-robin debounce engine sharing one prescaler and one compare unit across all GPIO inputs
module gpio_debounce_scheduler #(
    parameter int NCH      = 13,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 100
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [NCH-1:0]   raw_in,
    input  logic [NCH-1:0]   deb_en,
    input  logic [CNT_W-1:0] deb_time,
    output logic [NCH-1:0]   clean_out,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall,
    output logic             busy,
    output logic             overrun
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] LAST = PW'(NCH - 1);
    localparam logic [15:0] PS_LAST = 16'(TICK_DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state;
    logic [NCH-1:0]   sync1, sync2, clean_nxt;
    logic [15:0]      ps;
    logic [PW-1:0]    ptr;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W:0]   cur_inc;
    logic             cur_sync, cur_clean, tick;

    assign tick      = ps == PS_LAST;
    assign cur_cnt   = cnt[ptr];
    assign cur_sync  = sync2[ptr];
    assign cur_clean = clean_out[ptr];
    assign cur_inc   = {1'b0, cur_cnt} + (CNT_W+1)'(1);

    // two-flop synchroniser on the asynchronous pad inputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // shared sample-tick prescaler, tick on the last count of each period
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) ps <= '0;
        else          ps <= tick ? '0 : ps + 16'd1;
    end

    // scan scheduler: one pass over all channels per tick, threshold frozen for the pass
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            ptr     <= '0;
            thr     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= tick && (state == SCAN);
            if (state == IDLE) begin
                if (tick) begin
                    state <= SCAN;
                    ptr   <= '0;
                    thr   <= (deb_time == '0) ? CNT_W'(1) : deb_time;
                    busy  <= 1'b1;
                end
            end else if (ptr == LAST) begin
                state <= IDLE;
                ptr   <= '0;
                busy  <= 1'b0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

    // shared compare/increment for the visited channel; bypassed channels follow sync directly
    always_comb begin
        clean_nxt = clean_out;
        cnt_nxt   = cnt;
        if (state == SCAN && deb_en[ptr]) begin
            if (cur_sync == cur_clean) begin
                cnt_nxt[ptr] = '0;
            end else if (cur_inc >= {1'b0, thr}) begin
                clean_nxt[ptr] = cur_sync;
                cnt_nxt[ptr]   = '0;
            end else begin
                cnt_nxt[ptr] = (&cur_cnt) ? cur_cnt : cur_inc[CNT_W-1:0];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!deb_en[i]) begin
                clean_nxt[i] = sync2[i];
                cnt_nxt[i]   = '0;
            end
        end
    end

    // registered clean levels, edge pulses and per-channel counters
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            clean_out <= '0;
            rise      <= '0;
            fall      <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            clean_out <= clean_nxt;
            rise      <= clean_nxt & ~clean_out;
            fall      <= ~clean_nxt & clean_out;
            cnt       <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_gpio_debounce_scheduler.sv
// tb_gpio_debounce_scheduler: scoreboard bench for the debounce scheduler
module tb_gpio_debounce_scheduler;
    localparam int NCH = 13;
    localparam int T   = 100;
    localparam int TO  = 10;

    typedef struct {
        int ch;
        bit r;
        int cyc;
    } ev_t;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic rst_o = 1'b0;
    logic [NCH-1:0] raw_in = '0;
    logic [NCH-1:0] deb_en = 13'h1FFE;
    logic [15:0] deb_time = 16'd3;
    logic [NCH-1:0] clean_out, rise, fall;
    logic busy, overrun;
    logic [NCH-1:0] clean_o, rise_o, fall_o;
    logic busy_o, ovr_o;

    int n_chk = 0;
    int n_fail = 0;
    int rcyc = 0;
    int rcyc_o = 0;
    ev_t q[$];

    always #5 ACLK = ~ACLK;

    gpio_debounce_scheduler #(.NCH(NCH), .CNT_W(16), .TICK_DIV(T)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .raw_in(raw_in), .deb_en(deb_en), .deb_time(deb_time),
        .clean_out(clean_out), .rise(rise), .fall(fall), .busy(busy), .overrun(overrun)
    );

    gpio_debounce_scheduler #(.NCH(NCH), .CNT_W(16), .TICK_DIV(TO)) u_ovr (
        .ACLK(ACLK), .ARESETn(rst_o), .raw_in(raw_in), .deb_en(deb_en), .deb_time(deb_time),
        .clean_out(clean_o), .rise(rise_o), .fall(fall_o), .busy(busy_o), .overrun(ovr_o)
    );

    always @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) rcyc <= 0;
        else rcyc <= rcyc + 1;

    always @(posedge ACLK or negedge rst_o)
        if (!rst_o) rcyc_o <= 0;
        else rcyc_o <= rcyc_o + 1;

    always @(negedge ACLK) begin
        if (ARESETn) begin
            while (q.size() != 0 && q[0].cyc < rcyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missed_edge: ch%0d rise=%0d expected at cycle %0d, not seen by cycle %0d", q[0].ch, q[0].r, q[0].cyc, rcyc);
                void'(q.pop_front());
            end
            for (int c = 0; c < NCH; c++) begin
                if (rise[c] || fall[c]) begin
                    n_chk++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_edge: ch%0d rise=%0d fall=%0d at cycle %0d, required none", c, rise[c], fall[c], rcyc);
                    end else begin
                        ev_t e;
                        e = q.pop_front();
                        if (e.ch !== c || e.r !== rise[c] || e.cyc !== rcyc || (rise[c] && fall[c])) begin
                            n_fail++;
                            $display("FAIL edge: got ch%0d rise=%0d fall=%0d cycle %0d, required ch%0d rise=%0d cycle %0d",
                                     c, rise[c], fall[c], rcyc, e.ch, e.r, e.cyc);
                        end
                    end
                end
            end
        end
    end

    function automatic int visit(input int ch, input int e);
        int m;
        m = (e - 1 - ch + T - 1) / T;
        if (m < 1) m = 1;
        return m * T + 1 + ch;
    endfunction

    task automatic push(input int ch, input bit r, input int cyc);
        ev_t e;
        e.ch = ch;
        e.r = r;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d events outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic wait_phase(input int ph);
        do @(negedge ACLK); while (rcyc % T != ph);
    endtask

    task automatic test_reset;
        bit eb;
        ARESETn = 1'b0;
        rst_o = 1'b0;
        raw_in = '0;
        deb_time = 16'd3;
        deb_en = 13'h1FFE;
        repeat (3) @(negedge ACLK);
        n_chk++;
        if ({clean_out, rise, fall, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", {clean_out, rise, fall, busy, overrun});
        end
        ARESETn = 1'b1;
        for (int i = 0; i < 2 * T + 20; i++) begin
            @(negedge ACLK);
            eb = (rcyc >= T) && (rcyc % T <= 12);
            n_chk++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL idle_busy: cycle %0d busy=%0d, required %0d", rcyc, busy, eb);
            end
            n_chk++;
            if (overrun !== 1'b0 || clean_out !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs: cycle %0d overrun=%0d clean=%h, required 0/0", rcyc, overrun, clean_out);
            end
        end
    endtask

    task automatic test_press;
        int r0;
        @(negedge ACLK);
        r0 = rcyc;
        raw_in[10] = 1'b1;
        push(10, 1'b1, visit(10, r0 + 3) + 2 * T);
        drain(4 * T, "press");
        n_chk++;
        if (clean_out[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL press_level: clean[10]=%0d, required 1", clean_out[10]);
        end
        r0 = rcyc;
        raw_in[10] = 1'b0;
        push(10, 1'b0, visit(10, r0 + 3) + 2 * T);
        drain(4 * T, "release");
        n_chk++;
        if (clean_out[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_level: clean[10]=%0d, required 0", clean_out[10]);
        end
    endtask

    task automatic test_glitch;
        int r0;
        deb_time = 16'd5;
        wait_phase(20);
        wait_phase(20);
        raw_in[2] = 1'b1;
        repeat (250) @(negedge ACLK);
        raw_in[2] = 1'b0;
        repeat (2 * T) @(negedge ACLK);
        n_chk++;
        if (clean_out[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_level: clean[2]=%0d, required 0", clean_out[2]);
        end
        @(negedge ACLK);
        r0 = rcyc;
        raw_in[2] = 1'b1;
        push(2, 1'b1, visit(2, r0 + 3) + 4 * T);
        drain(6 * T, "glitch_restart");
        r0 = rcyc;
        raw_in[2] = 1'b0;
        push(2, 1'b0, visit(2, r0 + 3) + 4 * T);
        drain(6 * T, "glitch_release");
    endtask

    task automatic test_bypass;
        int r0;
        @(negedge ACLK);
        r0 = rcyc;
        raw_in[0] = 1'b1;
        push(0, 1'b1, r0 + 3);
        drain(10, "bypass_rise");
        n_chk++;
        if (clean_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_level: clean[0]=%0d, required 1", clean_out[0]);
        end
        r0 = rcyc;
        raw_in[0] = 1'b0;
        push(0, 1'b0, r0 + 3);
        drain(10, "bypass_fall");
        r0 = rcyc;
        raw_in[0] = 1'b1;
        @(negedge ACLK);
        raw_in[0] = 1'b0;
        push(0, 1'b1, r0 + 3);
        push(0, 1'b0, r0 + 4);
        drain(10, "bypass_pulse");
    endtask

    task automatic test_simultaneous;
        int r0;
        wait_phase(20);
        deb_time = 16'd0;
        wait_phase(20);
        r0 = rcyc;
        raw_in[12:8] = 5'h1F;
        for (int c = 8; c <= 12; c++) push(c, 1'b1, visit(c, r0 + 3));
        drain(2 * T, "simul_rise");
        n_chk++;
        if (clean_out[12:8] !== 5'h1F) begin
            n_fail++;
            $display("FAIL simul_level: clean[12:8]=%h, required 1f", clean_out[12:8]);
        end
        wait_phase(20);
        r0 = rcyc;
        raw_in[12:8] = 5'h00;
        for (int c = 8; c <= 12; c++) push(c, 1'b0, visit(c, r0 + 3));
        wait_phase(3);
        deb_time = 16'd2;
        drain(2 * T, "simul_fall");
        wait_phase(20);
        r0 = rcyc;
        raw_in[9] = 1'b1;
        push(9, 1'b1, visit(9, r0 + 3) + T);
        drain(3 * T, "thr2_rise");
        r0 = rcyc;
        raw_in[9] = 1'b0;
        push(9, 1'b0, visit(9, r0 + 3) + T);
        drain(3 * T, "thr2_fall");
    endtask

    task automatic test_overrun;
        bit eb, eo;
        @(negedge ACLK);
        rst_o = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            eb = (rcyc_o >= TO) && ((rcyc_o - TO) % 20 <= 12);
            eo = (rcyc_o >= 20) && (rcyc_o % 20 == 0);
            n_chk++;
            if (busy_o !== eb || ovr_o !== eo) begin
                n_fail++;
                $display("FAIL overrun: cycle %0d busy=%0d overrun=%0d, required %0d/%0d", rcyc_o, busy_o, ovr_o, eb, eo);
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        int r0, v1;
        deb_time = 16'd3;
        wait_phase(20);
        wait_phase(20);
        r0 = rcyc;
        raw_in[10] = 1'b1;
        v1 = visit(10, r0 + 3);
        while (rcyc < v1 + T - 6) @(negedge ACLK);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_busy: busy=%0d, required 1", busy);
        end
        ARESETn = 1'b0;
        #1;
        n_chk++;
        if ({clean_out, rise, fall, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL midscan_reset: got %h, required 0", {clean_out, rise, fall, busy, overrun});
        end
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        push(10, 1'b1, visit(10, 3) + 2 * T);
        drain(4 * T, "restart_rise");
        n_chk++;
        if (clean_out[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_level: clean[10]=%0d, required 1", clean_out[10]);
        end
        r0 = rcyc;
        raw_in[10] = 1'b0;
        push(10, 1'b0, visit(10, r0 + 3) + 2 * T);
        drain(4 * T, "restart_fall");
    endtask

    initial begin
        test_reset;
        test_press;
        test_glitch;
        test_bypass;
        test_simultaneous;
        test_overrun;
        test_reset_mid_scan;
        repeat (5) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
